// File: rtl/baccarat_hand_dealer.sv
`timescale 1ns/1ps
// baccarat_hand_dealer: holds one baccarat hand of up to three cards. Each
// card is drawn from a free-running 1..13 rank counter when requested, and
// the hand score (sum of card values mod 10) is kept in a register.
// Optional build macro BACCARAT_HAND_FORCE_EN adds force_en/force_card so a
// chosen rank can be loaded in place of the counter value.
module baccarat_hand_dealer #(
    parameter int DRAW_CYCLES = 4,
    parameter int SEED        = 1
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       deal_req,
    input  logic       clear_hand,
`ifdef BACCARAT_HAND_FORCE_EN
    input  logic       force_en,
    input  logic [3:0] force_card,
`endif
    output logic [3:0] card1,
    output logic [3:0] card2,
    output logic [3:0] card3,
    output logic [1:0] num_cards,
    output logic [3:0] score,
    output logic       deal_ack,
    output logic       deal_err
);

    localparam logic [3:0] SEED_RANK  = (SEED >= 1 && SEED <= 13) ? 4'(SEED) : 4'd1;
    localparam logic [3:0] DRAW_START = 4'(DRAW_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, DRAW, LOAD, SCORE, ACK} state_t;

    state_t     state, state_nxt;
    logic [3:0] draw_cnt, draw_cnt_nxt;
    logic [3:0] rank;
    logic [3:0] load_val;
    logic [4:0] sum;
    logic [4:0] sum_mod;

    // Baccarat value of a rank: pips count face value, tens and faces count zero.
    function automatic logic [4:0] card_value(input logic [3:0] r);
        return (r >= 4'd1 && r <= 4'd9) ? {1'b0, r} : 5'd0;
    endfunction

    // Rank counter runs in every state, wrapping 13 -> 1, never showing 0.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)            rank <= SEED_RANK;
        else if (rank >= 4'd13) rank <= 4'd1;
        else                    rank <= rank + 4'd1;
    end

    // Next-state logic. DRAW leaves when the decremented count reaches zero,
    // so together with LOAD the card lands DRAW_CYCLES edges after the
    // request was sampled; a one-cycle draw skips DRAW entirely.
    always_comb begin
        state_nxt    = state;
        draw_cnt_nxt = draw_cnt;
        case (state)
            IDLE: begin
                if (deal_req && num_cards != 2'd3) begin
                    draw_cnt_nxt = DRAW_START;
                    state_nxt    = (DRAW_CYCLES <= 1) ? LOAD : DRAW;
                end
            end
            DRAW: begin
                draw_cnt_nxt = draw_cnt - 4'd1;
                if (draw_cnt <= 4'd1) state_nxt = LOAD;
            end
            LOAD:    state_nxt = SCORE;
            SCORE:   state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (clear_hand) begin
            state_nxt    = IDLE;
            draw_cnt_nxt = 4'd0;
        end
    end

    // FSM state and draw counter registers.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            draw_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            draw_cnt <= draw_cnt_nxt;
        end
    end

    // Value written into the next free slot; forced ranks outside 1..13 load as ace.
    always_comb begin
        load_val = rank;
`ifdef BACCARAT_HAND_FORCE_EN
        if (force_en) begin
            load_val = (force_card == 4'd0 || force_card > 4'd13) ? 4'd1 : force_card;
        end
`endif
    end

    // Hand score: 5-bit sum (max 27) reduced modulo 10.
    always_comb begin
        sum     = card_value(card1) + card_value(card2) + card_value(card3);
        sum_mod = sum;
        if (sum >= 5'd20)      sum_mod = sum - 5'd20;
        else if (sum >= 5'd10) sum_mod = sum - 5'd10;
    end

    // Hand registers and one-cycle status pulses; clear_hand overrides everything.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            card1     <= 4'd0;
            card2     <= 4'd0;
            card3     <= 4'd0;
            num_cards <= 2'd0;
            score     <= 4'd0;
            deal_ack  <= 1'b0;
            deal_err  <= 1'b0;
        end else if (clear_hand) begin
            card1     <= 4'd0;
            card2     <= 4'd0;
            card3     <= 4'd0;
            num_cards <= 2'd0;
            score     <= 4'd0;
            deal_ack  <= 1'b0;
            deal_err  <= 1'b0;
        end else begin
            deal_ack <= 1'b0;
            deal_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (deal_req && num_cards == 2'd3) deal_err <= 1'b1;
                end
                LOAD: begin
                    case (num_cards)
                        2'd0:    card1 <= load_val;
                        2'd1:    card2 <= load_val;
                        2'd2:    card3 <= load_val;
                        default: ;
                    endcase
                    num_cards <= num_cards + 2'd1;
                end
                SCORE: begin
                    score    <= sum_mod[3:0];
                    deal_ack <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/baccarat_hand_dealer.md
Name: baccarat_hand_dealer

Overview:
- Upstream stage of the 7-segment card display decoders.
- Holds one baccarat hand of up to three cards and draws each new card from an internal free-running 1..13 rank counter on request.
- Presents each card as a 4-bit rank (0 = empty slot, displayed blank; 1..13 = A..K) plus the registered hand score.
- Each card output drives one 7-seg decoder directly; the dealer FSM pulses deal_req and waits for deal_ack.

Parameters:
- DRAW_CYCLES, 4: cycles spent in DRAW before the card is latched (1..15).
- SEED, 1: rank counter value after reset. Values outside 1..13 are replaced by 1.

Ports:
- slow_clock  in  1  single clock; all state on rising edge
- resetb  in  1  asynchronous, active-low reset
- deal_req  in  1  request one card; sampled only in IDLE
- clear_hand  in  1  synchronous hand clear; highest priority after reset
- card1  out  4  first card rank, 0 = empty
- card2  out  4  second card rank, 0 = empty
- card3  out  4  third card rank, 0 = empty
- num_cards  out  2  cards held, 0..3
- score  out  4  hand score, 0..9
- deal_ack  out  1  one-cycle pulse: card loaded and score updated
- deal_err  out  1  one-cycle pulse: request made while the hand is full

Behaviour:
- Reset (resetb low, asynchronous):
  - card1..3, num_cards, score, deal_ack and deal_err = 0.
  - State = IDLE.
  - Rank counter = SEED.
- Rank counter:
  - Advances every cycle in every state: 1 → 2 → … → 13 → 1.
  - Never 0.
- FSM states: IDLE, DRAW, LOAD, SCORE, ACK.
  - IDLE, deal_req=1, num_cards<3: go to DRAW, draw_cnt = DRAW_CYCLES-1.
  - IDLE, deal_req=1, num_cards==3: deal_err=1 for the next cycle; state stays IDLE; no data changes.
  - DRAW: draw_cnt decrements each cycle. When draw_cnt==0, go to LOAD.
  - LOAD (one cycle):
    - The slot indexed by num_cards (0→card1, 1→card2, 2→card3) takes the rank counter value present before this edge.
    - num_cards increments.
    - Go to SCORE.
  - SCORE (one cycle):
    - score <= (v(card1)+v(card2)+v(card3)) mod 10.
    - v(r) = r for r in 1..9; v(r) = 0 for r=0 and for r in 10..13.
    - 5-bit intermediate sum (max 27); result in 0..9.
    - Go to ACK.
  - ACK: deal_ack=1 for exactly this cycle; go to IDLE.
- Latency, with deal_req sampled at edge E0:
  - Card visible after edge E0+DRAW_CYCLES.
  - score updated after edge E0+DRAW_CYCLES+1.
  - deal_ack high in the cycle after edge E0+DRAW_CYCLES+1.
- deal_req outside IDLE is ignored. Requests are not queued. Holding deal_req high deals one card per pass through IDLE.
- clear_hand=1 in any state:
  - Next edge: card1..3, num_cards and score = 0; state = IDLE.
  - Aborts any deal in progress; no deal_ack or deal_err is issued.
  - Rank counter is unaffected.
  - Simultaneous deal_req is dropped.
- deal_ack and deal_err are never high in the same cycle.
- Unused card slots always read 0.

Optional Feature:
- Macro: BACCARAT_HAND_FORCE_EN.
- Defined:
  - Adds ports force_en (in, 1) and force_card (in, 4).
  - In LOAD with force_en=1, the slot takes force_card instead of the counter value.
  - force_card values 0 or 14..15 load as 1.
  - All timing unchanged.
- Undefined: ports absent; cards come only from the counter.

Test Plan:
- Reset, then idle 3 cycles → cards 0, num_cards 0, score 0, deal_ack 0, deal_err 0.
- SEED=1, DRAW_CYCLES=4, deal_req high at the first post-reset edge only → card1=5 after edge 5; score=5 and deal_ack high after edge 6; num_cards=1.
- FORCE_EN, force 7 then 8 → card1=7, card2=8, score=5; then force 12 → card3=12, score=5, num_cards=3.
- Full hand of 13, 9, 3 (score 2), then deal_req → deal_err pulses one cycle; cards, score and num_cards unchanged; no deal_ack.
- clear_hand asserted during DRAW of the second card → after the next edge all cards 0, num_cards 0, score 0, state IDLE; no deal_ack.
- Long run with no requests → rank counter sequence wraps 13 → 1 and never shows 0 or 14..15; assert resetb low mid-DRAW → outputs 0 immediately, without waiting for a clock edge.
